// File: rtl/bsc_countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding used by
// both the RTL and its bench.
package bsc_countdown_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/bsc_countdown_timer_if.sv
// Control/status bundle of the countdown timer; the master drives commands,
// the timer (slave) returns count and status.
interface bsc_countdown_if #(
   parameter int WIDTH = 8
);
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             start;
   logic             stop;
   logic             tick;
   logic             auto_reload;
   logic [WIDTH-1:0] count;
   logic             running;
   logic             done;
   logic             expire;

   modport master (
      output load, load_value, start, stop, tick, auto_reload,
      input  count, running, done, expire
   );

   modport slave (
      input  load, load_value, start, stop, tick, auto_reload,
      output count, running, done, expire
   );
endinterface

// File: rtl/bsc_countdown_timer.sv
// Loadable down-counter with start/stop control, optional auto-reload and a
// registered single-cycle expiry pulse.
module bsc_countdown_timer
   import bsc_countdown_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic     clk,
   input  logic     reset,
   bsc_countdown_if.slave bus
);

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   state_e           state_q;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] reload_q;
   logic             expire_q;

   // Priority chain: load, then stop (RUN only), then start (IDLE/DONE only), then tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= INIT;
         reload_q <= INIT;
         expire_q <= 1'b0;
      end else begin
         expire_q <= 1'b0;
         if (bus.load) begin
            count_q  <= bus.load_value;
            reload_q <= bus.load_value;
            state_q  <= IDLE;
         end else if (bus.stop && state_q == RUN) begin
            state_q <= IDLE;
         end else if (bus.start && state_q != RUN) begin
            if (count_q != ZERO) begin
               state_q <= RUN;
            end else begin
               state_q  <= DONE;
               expire_q <= 1'b1;
            end
         end else if (bus.tick && state_q == RUN) begin
            if (count_q == ONE) begin
               expire_q <= 1'b1;
               if (bus.auto_reload && reload_q != ZERO) begin
                  count_q <= reload_q;
               end else begin
                  count_q <= ZERO;
                  state_q <= DONE;
               end
            end else if (count_q != ZERO) begin
               count_q <= count_q - ONE;
            end
         end
      end
   end

   assign bus.count   = count_q;
   assign bus.running = (state_q == RUN);
   assign bus.done    = (state_q == DONE);
   assign bus.expire  = expire_q;

endmodule

`ifdef BSC_V1_PRIMITIVE
// Flat-port wrapper preserving the legacy V1 primitive pinout.
module CountdownTimer #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] DATA,
   input  logic             START,
   input  logic             STOP,
   input  logic             TICK,
   input  logic             RELOAD,
   output logic [WIDTH-1:0] Q_OUT,
   output logic             RUNNING,
   output logic             DONE,
   output logic             EXPIRE
);
   bsc_countdown_if #(.WIDTH(WIDTH)) bus ();

   assign bus.load        = LOAD;
   assign bus.load_value  = DATA;
   assign bus.start       = START;
   assign bus.stop        = STOP;
   assign bus.tick        = TICK;
   assign bus.auto_reload = RELOAD;
   assign Q_OUT           = bus.count;
   assign RUNNING         = bus.running;
   assign DONE            = bus.done;
   assign EXPIRE          = bus.expire;

   bsc_countdown_timer #(.WIDTH(WIDTH), .INIT(INIT)) u_timer (
      .clk   (CLK),
      .reset (RST),
      .bus   (bus.slave)
   );
endmodule
`endif

// File: doc/bsc_countdown_timer.md
BSC_COUNTDOWN_TIMER -- requirements
Module: bsc_countdown_timer

Interface
REQ-001 Parameter WIDTH, default 8: width of the count, load and reload values, in bits; legal range 1..64.
REQ-002 Parameter INIT, default 0: reset value of the count and reload registers.
REQ-003 clk  input  1: rising-edge clock.
REQ-004 reset  input  1: reset reset, synchronous, active-high.
REQ-005 load  input  1: load load_value into count and reload registers.
REQ-006 load_value  input  WIDTH: value captured on load.
REQ-007 start  input  1: begin or resume counting down.
REQ-008 stop  input  1: pause counting, holding the count.
REQ-009 tick  input  1: decrement enable, sampled only while running.
REQ-010 auto_reload  input  1: on expiry, reload from the reload register and keep running.
REQ-011 count  output  WIDTH: current count, registered.
REQ-012 running  output  1: high while state is RUN.
REQ-013 done  output  1: high while state is DONE.
REQ-014 expire  output  1: registered single-cycle pulse on each expiry.

Function
REQ-015 FSM states IDLE, RUN, DONE; running and done are decoded from the state register only.
REQ-016 Per-cycle input priority: load > stop > start > tick.
REQ-017 load, any state: count and reload <= load_value; state -> IDLE; expire = 0 next cycle.
REQ-018 stop in RUN: state -> IDLE, count held; stop in IDLE or DONE: no effect.
REQ-019 start in IDLE or DONE with count != 0: state -> RUN next cycle; start in RUN: no effect.
REQ-020 start in IDLE or DONE with count == 0: state -> DONE, expire pulses on the next cycle.
REQ-021 tick in RUN with count > 1: count <= count - 1 next cycle.
REQ-022 tick in RUN with count == 1, auto_reload = 1, reload != 0: count <= reload; stay in RUN; expire = 1 next cycle.
REQ-023 tick in RUN with count == 1, otherwise: count <= 0; state -> DONE; expire = 1 next cycle.
REQ-024 Expiry timing: expire is high in the same cycle that count first shows 0 or the reloaded value.
REQ-025 tick outside RUN: ignored; count never underflows below 0 or wraps.
REQ-026 load and tick in the same cycle: load wins; no decrement and no expiry.
REQ-027 Expiry latency: exactly N ticks after start for a loaded value N >= 1; idle cycles between ticks do not alter the count.
REQ-028 expire: never high two consecutive cycles except for back-to-back ticks with reload == 1 and auto_reload = 1, where it stays high every ticked cycle.
REQ-029 auto_reload: sampled only at the expiry cycle; changing it mid-count has no other effect.

Reset
REQ-030 On reset, which has priority over all inputs: count = INIT, reload = INIT, state = IDLE, running = 0, done = 0, expire = 0.
REQ-031 Reset asserted mid-RUN: the count is abandoned and no expire pulse is produced.
REQ-032 Without reset, the simulation-only initial value of the registers is the project's standard 0/1 fill pattern.

Structure
REQ-033 A shared package bsc_countdown_pkg holds the state enum (IDLE, RUN, DONE) and is used by both the RTL and the bench.
REQ-034 Single flat module: one count register, one reload register, one state register and one expire flop; no sub-module.
REQ-035 A V1 shim named CountdownTimer (CLK, RST, LOAD, DATA, START, STOP, TICK, RELOAD, Q_OUT, RUNNING, DONE, EXPIRE) exists under the V1-primitive define.

Verification
REQ-036 WIDTH=8, load 3, start, tick every cycle -> count 3,2,1,0; expire high with count=0; done=1 after; running=0.
REQ-037 Load 2, auto_reload=1, start, 6 ticks -> count 2,1,2,1,2,1,2; expire high on the 2nd, 4th and 6th tick responses; running stays 1.
REQ-038 Load 5, start, 2 ticks, stop, 3 ticks, start, 3 ticks -> count holds 3 while stopped; expire after the final tick; count 0.
REQ-039 Load 0, start -> done=1 and one expire pulse next cycle; further ticks leave count at 0 and produce no pulse.
REQ-040 Load 4, start, tick to 1, then assert load=9 together with tick -> count=9, state IDLE, no expire.
REQ-041 Load 4, start, 2 ticks, reset -> count=INIT, IDLE, no expire for 5 cycles of continuous tick.
